// File: rtl/gate_compare_sequencer.sv
// gate_compare_sequencer
//   Controller for a gate spec-vs-impl equivalence harness. Sweeps every
//   {0,1,X,Z}^NSRC source combination onto a shared source bus, waits SETTLE
//   cycles, samples both output vectors, classifies mismatches as
//   conservative (impl reads X) or failing, accumulates saturating counts and
//   hands one record per mismatching vector to a logger (valid/ready).
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   start                  begin sweep (honoured only in IDLE or DONE)
//   src_code   [2*NSRC]    source drive, 2 bits/src (00=0 01=1 10=X 11=Z)
//   check                  one-cycle pulse in the sample cycle
//   spec_code  [2*NOUT]    spec outputs, same encoding
//   impl_code  [2*NOUT]    impl outputs, same encoding
//   rec_valid/rec_ready    mismatch record handshake
//   rec_vec    [2*NSRC]    source vector of the record
//   rec_fail   [NOUT]      outputs mismatching with impl != X
//   rec_cons   [NOUT]      outputs mismatching with impl == X
//   busy, done             sweep in progress / sweep finished
//   fail_cnt, cons_cnt     saturating totals of failing / conservative outputs
module gate_compare_sequencer #(
    parameter int NSRC   = 3,
    parameter int NOUT   = 18,
    parameter int SETTLE = 4,
    parameter int CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [2*NSRC-1:0]    src_code,
    output logic                 check,
    input  logic [2*NOUT-1:0]    spec_code,
    input  logic [2*NOUT-1:0]    impl_code,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [2*NSRC-1:0]    rec_vec,
    output logic [NOUT-1:0]      rec_fail,
    output logic [NOUT-1:0]      rec_cons,
    output logic                 busy,
    output logic                 done,
    output logic [CNTW-1:0]      fail_cnt,
    output logic [CNTW-1:0]      cons_cnt
);

    localparam int IW  = 2 * NSRC;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PCW = $clog2(NOUT + 1);
    // Sum width wide enough that any carry past CNTW bits is visible.
    localparam int SW  = ((CNTW > PCW) ? CNTW : PCW) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_REPORT, S_NEXT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     src_q, src_d;
    logic [SCW-1:0]    settle_q, settle_d;
    logic [CNTW-1:0]   fail_cnt_q, fail_cnt_d;
    logic [CNTW-1:0]   cons_cnt_q, cons_cnt_d;
    logic [IW-1:0]     rec_vec_q, rec_vec_d;
    logic [NOUT-1:0]   rec_fail_q, rec_fail_d;
    logic [NOUT-1:0]   rec_cons_q, rec_cons_d;

    logic [NOUT-1:0]   mm, cons_v, fail_v;
    logic              last_idx, settle_last, restart;

    function automatic logic [PCW-1:0] popcount(input logic [NOUT-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int unsigned k = 0; k < NOUT; k++) c = c + PCW'(v[k]);
        return c;
    endfunction

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                                 input logic [PCW-1:0]  b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (|s[SW-1:CNTW]) return '1;
        return s[CNTW-1:0];
    endfunction

    always_comb begin
        mm     = '0;
        cons_v = '0;
        fail_v = '0;
        for (int unsigned k = 0; k < NOUT; k++) begin
            mm[k]     = spec_code[2*k +: 2] != impl_code[2*k +: 2];
            cons_v[k] = mm[k] && (impl_code[2*k +: 2] == 2'b10);
            fail_v[k] = mm[k] && !cons_v[k];
        end
    end

    assign last_idx    = &idx_q;
    assign settle_last = settle_q == SCW'(SETTLE - 1);
    assign restart     = start && (state_q == S_IDLE || state_q == S_DONE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_DRIVE;
            S_DRIVE:        state_d = S_SETTLE;
            S_SETTLE:       if (settle_last) state_d = S_CHECK;
            S_CHECK:        state_d = (|mm) ? S_REPORT : S_NEXT;
            S_REPORT:       if (rec_ready) state_d = S_NEXT;
            S_NEXT:         state_d = last_idx ? S_DONE : S_DRIVE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        idx_d      = idx_q;
        src_d      = src_q;
        settle_d   = settle_q;
        fail_cnt_d = fail_cnt_q;
        cons_cnt_d = cons_cnt_q;
        rec_vec_d  = rec_vec_q;
        rec_fail_d = rec_fail_q;
        rec_cons_d = rec_cons_q;
        if (restart) begin
            idx_d      = '0;
            fail_cnt_d = '0;
            cons_cnt_d = '0;
        end
        unique case (state_q)
            S_DRIVE: begin
                src_d    = idx_q;
                settle_d = '0;
            end
            S_SETTLE: settle_d = settle_q + SCW'(1);
            S_CHECK: begin
                fail_cnt_d = sat_add(fail_cnt_q, popcount(fail_v));
                cons_cnt_d = sat_add(cons_cnt_q, popcount(cons_v));
                if (|mm) begin
                    rec_vec_d  = src_q;
                    rec_fail_d = fail_v;
                    rec_cons_d = cons_v;
                end
            end
            // Terminal vector goes to DONE without advancing, so idx never wraps.
            S_NEXT: if (!last_idx) idx_d = idx_q + IW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            src_q      <= '0;
            settle_q   <= '0;
            fail_cnt_q <= '0;
            cons_cnt_q <= '0;
            rec_vec_q  <= '0;
            rec_fail_q <= '0;
            rec_cons_q <= '0;
        end else begin
            idx_q      <= idx_d;
            src_q      <= src_d;
            settle_q   <= settle_d;
            fail_cnt_q <= fail_cnt_d;
            cons_cnt_q <= cons_cnt_d;
            rec_vec_q  <= rec_vec_d;
            rec_fail_q <= rec_fail_d;
            rec_cons_q <= rec_cons_d;
        end
    end

    // Output logic
    always_comb begin
        check     = state_q == S_CHECK;
        rec_valid = state_q == S_REPORT;
        busy      = !(state_q == S_IDLE || state_q == S_DONE);
        done      = state_q == S_DONE;
    end

    assign src_code = src_q;
    assign rec_vec  = rec_vec_q;
    assign rec_fail = rec_fail_q;
    assign rec_cons = rec_cons_q;
    assign fail_cnt = fail_cnt_q;
    assign cons_cnt = cons_cnt_q;

endmodule
